// File: rtl/dft_pkg.sv
// Shared constants, helpers and the result tag type for the DFT butterfly datapath.
package dft_pkg;

  localparam int unsigned DFT_MAX_REQ = 8;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned dft_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DFT_TAG_ID_W = dft_idx_w(DFT_MAX_REQ);

  typedef struct packed {
    logic                    valid;
    logic [DFT_TAG_ID_W-1:0] id;
  } dft_tag_t;

endpackage

// File: rtl/dft_add.sv
// Pipelined adder; latency = INPUT_REG + OUTPUT_REG + PIPELINE_STAGES, result wraps modulo 2^DATA_W.
module dft_add #(
  parameter int unsigned DATA_W          = 32,
  parameter string       DATA_SIGNED     = "off",
  parameter string       INPUT_REG       = "off",
  parameter string       OUTPUT_REG      = "on",
  parameter int unsigned PIPELINE_STAGES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned DEPTH = ((INPUT_REG == "on") ? 1 : 0)
                                + ((OUTPUT_REG == "on") ? 1 : 0)
                                + PIPELINE_STAGES;

  logic [DATA_W-1:0] w_sum;

  if (DATA_SIGNED == "on") begin : g_signed
    assign w_sum = DATA_W'($signed(data_a) + $signed(data_b));
  end else begin : g_unsigned
    assign w_sum = data_a + data_b;
  end

  // Register placement inside the chain is functionally irrelevant, so all stages sit after the sum.
  if (DEPTH == 0) begin : g_comb
    assign result = w_sum;
  end else begin : g_pipe
    logic [DATA_W-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= w_sum;
        for (int i = 1; i < int'(DEPTH); i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign result = r_pipe[DEPTH-1];
  end

endmodule

// File: rtl/dft_rr_arb.sv
// Combinational round-robin grant: first requester at or after i_ptr wins, one-hot plus encoded index.
module dft_rr_arb
  import dft_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = dft_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt_c,
  output logic [IDX_W-1:0]   o_idx_c,
  output logic               o_valid_c
);

  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] p, input int unsigned k);
    return IDX_W'((32'(p) + k) % NUM_REQ);
  endfunction

  logic             w_found;
  logic [IDX_W-1:0] w_j;

  always_comb begin
    o_gnt_c   = '0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    w_found   = 1'b0;
    w_j       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_j = rot_idx(i_ptr, k);
      if (i_en && !w_found && i_req[w_j]) begin
        w_found       = 1'b1;
        o_gnt_c[w_j]  = 1'b1;
        o_idx_c       = w_j;
        o_valid_c     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dft_add_arb.sv
// Time-shares one dft_add between NUM_REQ requesters; a tag pipeline returns each sum with its requester id.
module dft_add_arb
  import dft_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = 4,
  parameter  int unsigned DATA_W      = 32,
  parameter  string       DATA_SIGNED = "off",
  parameter  int unsigned ADD_LAT     = 1,
  localparam int unsigned IDX_W       = dft_idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      res_valid,
  output logic [IDX_W-1:0]          res_id,
  output logic [DATA_W-1:0]         res_data,
  output logic                      busy
);

  localparam int unsigned LAST = ADD_LAT - 1;

  if (NUM_REQ < 2 || NUM_REQ > DFT_MAX_REQ) begin : g_bad_num_req
    $error("dft_add_arb: NUM_REQ out of range");
  end
  if (ADD_LAT < 1) begin : g_bad_lat
    $error("dft_add_arb: ADD_LAT must be at least 1");
  end

  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_xfer;
  logic               w_busy;

  logic [IDX_W-1:0]   r_ptr;
  dft_tag_t           r_tag [ADD_LAT];
  logic [DATA_W-1:0]  r_op_a;
  logic [DATA_W-1:0]  r_op_b;
  logic               r_res_valid;
  logic [IDX_W-1:0]   r_res_id;

  // Reset gates the arbiter so no grant is visible while rst is low.
  dft_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .i_en      (en & rst),
    .o_gnt_c   (w_gnt),
    .o_idx_c   (w_gnt_idx),
    .o_valid_c (w_xfer)
  );

  assign req_ready = w_gnt;

  // Pointer and tag pipeline; the extra output register lines the tag up with the operand register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
      for (int i = 0; i < int'(ADD_LAT); i++) r_tag[i] <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
    end else begin
      if (w_xfer) r_ptr <= IDX_W'((32'(w_gnt_idx) + 1) % NUM_REQ);
      r_tag[0].valid <= w_xfer;
      r_tag[0].id    <= DFT_TAG_ID_W'(w_gnt_idx);
      for (int i = 1; i < int'(ADD_LAT); i++) r_tag[i] <= r_tag[i-1];
      r_res_valid <= r_tag[LAST].valid;
      r_res_id    <= IDX_W'(r_tag[LAST].id);
    end
  end

  // Operand holding register; contents are don't-care between transfers.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_op_a <= req_a[32'(w_gnt_idx)*DATA_W +: DATA_W];
      r_op_b <= req_b[32'(w_gnt_idx)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < int'(ADD_LAT); i++) w_busy = w_busy | r_tag[i].valid;
  end

  assign busy      = w_busy;
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;

  dft_add #(
    .DATA_W          (DATA_W),
    .DATA_SIGNED     (DATA_SIGNED),
    .INPUT_REG       ("off"),
    .OUTPUT_REG      ("on"),
    .PIPELINE_STAGES (ADD_LAT - 1)
  ) u_add (
    .clk    (clk),
    .rst    (~rst),
    .data_a (r_op_a),
    .data_b (r_op_b),
    .result (res_data)
  );

endmodule
